// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/forwarding controller for a five-stage pipeline.
//               Holds or bubbles the F/D, D/E, E/M and M/W registers, selects
//               E-stage operand forwarding, sequences instruction/data memory
//               waits and kills a wrong-path fetch still outstanding when the
//               PC is redirected.
//               Optional performance counters: HAZARD_PERF_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [REG_ADDR_W-1:0] iRs1D,
  input  logic [REG_ADDR_W-1:0] iRs2D,
  input  logic [REG_ADDR_W-1:0] iRs1E,
  input  logic [REG_ADDR_W-1:0] iRs2E,
  input  logic [REG_ADDR_W-1:0] iRdE,
  input  logic [REG_ADDR_W-1:0] iRdM,
  input  logic [REG_ADDR_W-1:0] iRdW,
  input  logic                  iMemReadE,
  input  logic                  iRegWriteM,
  input  logic                  iRegWriteW,
  input  logic                  iRedirectE,
  input  logic                  iFetchBusyF,
  input  logic                  iMemBusyM,
  output logic                  oStallF,
  output logic                  oStallD,
  output logic                  oStallE,
  output logic                  oStallM,
  output logic                  oFlushD,
  output logic                  oFlushE,
  output logic                  oFlushW,
  output logic                  oKillF,
  output logic [FWD_W-1:0]      oForwardAE,
  output logic [FWD_W-1:0]      oForwardBE,
  output logic [31:0]           oStallCycles,
  output logic [31:0]           oFlushCount
);

  localparam logic [FWD_W-1:0]      FWD_RF   = FWD_W'(0);
  localparam logic [FWD_W-1:0]      FWD_WB   = FWD_W'(1);
  localparam logic [FWD_W-1:0]      FWD_MALU = FWD_W'(2);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  state_t state;
  state_t next_state;
  logic   load_use;

  // State register; reset abandons any outstanding wait.
  always_ff @(posedge iClk) begin
    if (iRst) state <= RUN;
    else      state <= next_state;
  end

  // Operand forwarding: the younger M result has priority over W.
  always_comb begin
    oForwardAE = FWD_RF;
    oForwardBE = FWD_RF;
    if (!iRst) begin
      if (iRegWriteM && (iRdM != REG_ZERO) && (iRdM == iRs1E))      oForwardAE = FWD_MALU;
      else if (iRegWriteW && (iRdW != REG_ZERO) && (iRdW == iRs1E)) oForwardAE = FWD_WB;
      if (iRegWriteM && (iRdM != REG_ZERO) && (iRdM == iRs2E))      oForwardBE = FWD_MALU;
      else if (iRegWriteW && (iRdW != REG_ZERO) && (iRdW == iRs2E)) oForwardBE = FWD_WB;
    end
  end

  assign load_use = iMemReadE && (iRdE != REG_ZERO) && ((iRdE == iRs1D) || (iRdE == iRs2D));

  // Prioritised stall/flush decode and next-state logic.
  always_comb begin
    next_state = state;
    oStallF    = 1'b0;
    oStallD    = 1'b0;
    oStallE    = 1'b0;
    oStallM    = 1'b0;
    oFlushD    = 1'b0;
    oFlushE    = 1'b0;
    oFlushW    = 1'b0;
    oKillF     = 1'b0;
    if (iRst) begin
      next_state = RUN;
      oFlushD    = 1'b1;
      oFlushE    = 1'b1;
      oFlushW    = 1'b1;
    end else begin
      if (iMemBusyM) begin
        // E is held, so redirect/load-use stay visible once memory returns.
        oStallF = 1'b1;
        oStallD = 1'b1;
        oStallE = 1'b1;
        oStallM = 1'b1;
        oFlushW = 1'b1;
      end else if (iRedirectE) begin
        oFlushD = 1'b1;
        oFlushE = 1'b1;
      end else if (load_use) begin
        oStallF = 1'b1;
        oStallD = 1'b1;
        oFlushE = 1'b1;
      end else if (iFetchBusyF) begin
        oStallF = 1'b1;
        oFlushD = 1'b1;
      end

      if (state == KILL) begin
        // Whatever reaches D while the stale fetch is pending is wrong-path.
        oFlushD = 1'b1;
        oKillF  = !iFetchBusyF;
        if (!iFetchBusyF && !(iRedirectE && !iMemBusyM)) next_state = RUN;
      end else if (iRedirectE && !iMemBusyM && iFetchBusyF) begin
        next_state = KILL;
      end
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  // Free-running wrap-around performance counters.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (oStallF) stall_cycles <= stall_cycles + 32'd1;
      if (oFlushE) flush_count  <= flush_count + 32'd1;
    end
  end

  assign oStallCycles = stall_cycles;
  assign oFlushCount  = flush_count;
`else
  assign oStallCycles = '0;
  assign oFlushCount  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl: directed scenarios followed
//               by randomized traffic, checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int FW = 2;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic          rst;
  logic [RW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic          memreade, regwritem, regwritew, redirecte, fetchbusyf, membusym;
  logic          stallf, stalld, stalle, stallm, flushd, flushe, flushw, killf;
  logic [FW-1:0] fwda, fwdb;
  logic [31:0]   stall_cycles, flush_count;

  hazard_ctrl #(.REG_ADDR_W(RW), .FWD_W(FW)) dut (
    .iClk(clk), .iRst(rst),
    .iRs1D(rs1d), .iRs2D(rs2d), .iRs1E(rs1e), .iRs2E(rs2e),
    .iRdE(rde), .iRdM(rdm), .iRdW(rdw),
    .iMemReadE(memreade), .iRegWriteM(regwritem), .iRegWriteW(regwritew),
    .iRedirectE(redirecte), .iFetchBusyF(fetchbusyf), .iMemBusyM(membusym),
    .oStallF(stallf), .oStallD(stalld), .oStallE(stalle), .oStallM(stallm),
    .oFlushD(flushd), .oFlushE(flushe), .oFlushW(flushw), .oKillF(killf),
    .oForwardAE(fwda), .oForwardBE(fwdb),
    .oStallCycles(stall_cycles), .oFlushCount(flush_count)
  );

  typedef struct packed {
    logic [11:0] ctl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        cnt_ok;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Model state: a wrong-path fetch is outstanding; counter shadows.
  bit          m_pending = 1'b0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;
  bit          m_cnt_ok = 1'b0;

  function automatic logic [1:0] fwd_of(input logic [RW-1:0] rs);
    if (regwritem && rdm != 0 && rdm == rs) return 2'b10;
    if (regwritew && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compute expected response for current inputs, enqueue, advance a cycle.
  task automatic step();
    exp_t e;
    bit sF, sD, sE, sM, fD, fE, fW, k, lu, redirect_taken;
    logic [1:0] fa, fb;
    {sF, sD, sE, sM, fD, fE, fW, k} = '0;
    fa = 2'b00;
    fb = 2'b00;
    e.sc     = m_sc;
    e.fc     = m_fc;
    e.cnt_ok = m_cnt_ok;
    if (rst) begin
      fD = 1; fE = 1; fW = 1;
      m_pending = 0;
      m_sc = 0; m_fc = 0; m_cnt_ok = 1;
    end else begin
      fa = fwd_of(rs1e);
      fb = fwd_of(rs2e);
      lu = memreade && rde != 0 && (rde == rs1d || rde == rs2d);
      redirect_taken = redirecte && !membusym;
      if (membusym)        begin sF = 1; sD = 1; sE = 1; sM = 1; fW = 1; end
      else if (redirecte)  begin fD = 1; fE = 1; end
      else if (lu)         begin sF = 1; sD = 1; fE = 1; end
      else if (fetchbusyf) begin sF = 1; fD = 1; end
      if (m_pending) begin
        fD = 1;
        k  = !fetchbusyf;
        m_pending = fetchbusyf || redirect_taken;
      end else begin
        m_pending = redirect_taken && fetchbusyf;
      end
      if (sF) m_sc = m_sc + 1;
      if (fE) m_fc = m_fc + 1;
    end
    e.ctl = {sF, sD, sE, sM, fD, fE, fW, k, fa, fb};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {stallf, stalld, stalle, stallm, flushd, flushe, flushw, killf, fwda, fwdb};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL ctl cycle=%0d actual=%b required=%b (sF sD sE sM fD fE fW kill fwdA fwdB)",
                   cycle_no, act, e.ctl);
        end
`ifdef HAZARD_PERF_COUNTERS_EN
        if (e.cnt_ok) begin
          checks++;
          if (stall_cycles !== e.sc) begin
            failures++;
            $display("FAIL stall_cycles cycle=%0d actual=%0d required=%0d", cycle_no, stall_cycles, e.sc);
          end
          checks++;
          if (flush_count !== e.fc) begin
            failures++;
            $display("FAIL flush_count cycle=%0d actual=%0d required=%0d", cycle_no, flush_count, e.fc);
          end
        end
`endif
        cycle_no++;
      end
    end
  end

  task automatic clear_inputs();
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    {memreade, regwritem, regwritew, redirecte, fetchbusyf, membusym} = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();

    // Forwarding priority and zero-register handling
    regwritem = 1; rdm = 5; rs1e = 5; regwritew = 1; rdw = 5; rs2e = 5;
    step();
    rdm = 0;
    step();
    rs2e = 0; rdw = 0;
    step();
    clear_inputs();

    // Load-use single bubble
    memreade = 1; rde = 7; rs2d = 7;
    step();
    memreade = 0;
    step();
    clear_inputs();

    // Memory wait masking a held redirect
    membusym = 1; redirecte = 1;
    repeat (3) step();
    membusym = 0;
    step();
    redirecte = 0;
    step();

    // Redirect with busy fetch -> wrong-path kill
    redirecte = 1; fetchbusyf = 1;
    step();
    redirecte = 0;
    repeat (2) step();
    fetchbusyf = 0;
    step();
    step();

    // Redirect cancels coincident load-use
    redirecte = 1; memreade = 1; rde = 7; rs2d = 7;
    step();
    clear_inputs();
    step();

    // Reset mid-KILL
    redirecte = 1; fetchbusyf = 1;
    step();
    redirecte = 0;
    step();
    rst = 1;
    step();
    rst = 0; fetchbusyf = 0;
    repeat (2) step();

    // Randomized traffic with a small register pool to force hazards
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      rs1d       = RW'($urandom_range(0, 3));
      rs2d       = RW'($urandom_range(0, 3));
      rs1e       = RW'($urandom_range(0, 3));
      rs2e       = RW'($urandom_range(0, 3));
      rde        = RW'($urandom_range(0, 3));
      rdm        = RW'($urandom_range(0, 3));
      rdw        = RW'($urandom_range(0, 3));
      memreade   = ($urandom_range(0, 3) == 0);
      regwritem  = ($urandom_range(0, 1) == 0);
      regwritew  = ($urandom_range(0, 1) == 0);
      redirecte  = ($urandom_range(0, 5) == 0);
      fetchbusyf = ($urandom_range(0, 2) == 0);
      membusym   = ($urandom_range(0, 5) == 0);
      step();
    end
    clear_inputs();

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the five-stage pipeline.
- Drives stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage operand forwarding muxes.
- Sequences multi-cycle waits on instruction and data memory.
- Tracks wrong-path fetches that are still outstanding when a redirect occurs.
- Sits beside the datapath. Consumes register indices and control bits from D/E/M/W, busy flags from both memory ports, and the E-stage redirect.

Parameters:
- REG_ADDR_W, 5, register index width.
- FWD_W, 2, forward select width; encoding 00 = register file, 01 = W result, 10 = M ALU result.

Ports:
- iClk  in  1  clock.
- iRst  in  1  synchronous active-high reset.
- iRs1D, iRs2D  in  REG_ADDR_W  source regs of instruction in D.
- iRs1E, iRs2E  in  REG_ADDR_W  source regs in E.
- iRdE, iRdM, iRdW  in  REG_ADDR_W  destination regs in E/M/W.
- iMemReadE  in  1  instruction in E is a load.
- iRegWriteM, iRegWriteW  in  1  M/W instruction writes rd.
- iRedirectE  in  1  E resolved a mispredict/taken jump; PC redirect this cycle.
- iFetchBusyF  in  1  instruction memory has not returned this cycle.
- iMemBusyM  in  1  data memory access in M not complete.
- oStallF, oStallD, oStallE, oStallM  out  1  hold the corresponding register.
- oFlushD, oFlushE, oFlushW  out  1  load bubble into the D, E, W register.
- oKillF  out  1  instruction returning from the fetch port this cycle is wrong-path.
- oForwardAE, oForwardBE  out  FWD_W  operand forward selects.
- oStallCycles, oFlushCount  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset:
  - While iRst=1: state <= RUN; all stalls 0; oFlushD=oFlushE=oFlushW=1; oKillF=0; forwards 00.
  - Reset mid-wait abandons the wait: state returns to RUN the next cycle regardless of the busy inputs.
- States: RUN, KILL. Registered state; all other outputs are combinational from state and inputs.
- Forwarding (combinational, every cycle):
  - oForwardAE=10 if iRegWriteM and iRdM!=0 and iRdM==iRs1E.
  - Else 01 if iRegWriteW and iRdW!=0 and iRdW==iRs1E.
  - Else 00.
  - M has priority over W. oForwardBE is the same rule using iRs2E.
- Load-use (LU) = iMemReadE and iRdE!=0 and (iRdE==iRs1D or iRdE==iRs2D).
- Priority, highest first, in RUN:
  1. iMemBusyM: oStallF/D/E/M=1, oFlushW=1, no D/E flush. Redirect and LU are ignored this cycle; the inputs stay valid because E is held.
  2. iRedirectE: oFlushD=1, oFlushE=1, oStallF=oStallD=0. A coincident LU is cancelled.
     - If iFetchBusyF=1 in the same cycle, next state = KILL.
  3. LU: oStallF=1, oStallD=1, oFlushE=1. Single bubble; LU clears the next cycle when the load moves to M.
  4. iFetchBusyF: oStallF=1, oFlushD=1 (bubble into D; D/E continue).
  5. Otherwise: all stalls 0, all flushes 0.
  - LU and iFetchBusyF together: stallD wins and oFlushD=0.
- KILL state (a wrong-path fetch is outstanding):
  - Rules 1–4 apply unchanged, except oFlushD=1 in every KILL cycle.
  - On the first cycle with iFetchBusyF=0: oKillF=1, oFlushD=1, next state = RUN.
  - A new iRedirectE while in KILL keeps the state at KILL.
- oFlushW is asserted only by rule 1 and by reset.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined:
  - oStallCycles increments by 1 on each cycle with oStallF=1 and iRst=0.
  - oFlushCount increments by 1 on each cycle with oFlushE=1 from rule 2 or 3, excluding reset.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops are built.

Test Plan:
- Forwarding: iRegWriteM=1, iRdM=5, iRs1E=5; iRegWriteW=1, iRdW=5 -> oForwardAE=10. Set iRdM=0 -> oForwardAE=01. Set iRs2E=0, iRdW=0 -> oForwardBE=00.
- Load-use: iMemReadE=1, iRdE=7, iRs2D=7 -> one cycle of oStallF=oStallD=oFlushE=1. Next cycle (iMemReadE=0) -> all 0.
- Memory wait: iMemBusyM=1 for 3 cycles with iRedirectE=1 held -> stalls F/D/E/M=1 and oFlushW=1 for 3 cycles, no oFlushD. Cycle 4 -> oFlushD=oFlushE=1.
- Redirect with busy fetch: iRedirectE=1, iFetchBusyF=1 -> flushD/E, state KILL. Busy for 2 more cycles -> oFlushD=1, oKillF=0. Busy falls -> oKillF=1, oFlushD=1, then RUN.
- Redirect with coincident LU: both true -> oFlushD=oFlushE=1, oStallF=oStallD=0.
- Reset mid-KILL: assert iRst in KILL -> flushes D/E/W=1, oKillF=0. After release with iFetchBusyF=0 -> oKillF stays 0. With HAZARD_PERF_COUNTERS_EN, counters read 0.
